// File: rtl/timing_adapter_src_rl.sv
// timing_adapter_src_rl
// Avalon-ST source-side timing adapter. The upstream side uses ready latency 0
// and the downstream side uses ready latency READY_LATENCY. Upstream beats are
// held in a small FIFO. A beat is presented downstream only in a cycle whose
// slot was granted by out_ready READY_LATENCY cycles earlier.
// Payload order in storage: {data, sop, eop, empty}.
// Optional feature macro: TIMING_ADAPTER_SRC_PKTCHK_EN adds a sticky
// framing-error output (pkt_error) driven by a checker on accepted input beats.
module timing_adapter_src_rl #(
    parameter int DATA_WIDTH    = 32,
    parameter int EMPTY_WIDTH   = 2,
    parameter int READY_LATENCY = 2,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    output logic                           in_ready,
    input  logic                           in_valid,
    input  logic [DATA_WIDTH-1:0]          in_data,
    input  logic                           in_startofpacket,
    input  logic                           in_endofpacket,
    input  logic [EMPTY_WIDTH-1:0]         in_empty,
    input  logic                           out_ready,
    output logic                           out_valid,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic                           out_startofpacket,
    output logic                           out_endofpacket,
    output logic [EMPTY_WIDTH-1:0]         out_empty,
`ifdef TIMING_ADAPTER_SRC_PKTCHK_EN
    output logic                           pkt_error,
`endif
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fill_level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = DATA_WIDTH + 2 + EMPTY_WIDTH;
    localparam logic [FW-1:0] DEPTH_C = FW'(FIFO_DEPTH);

    logic [PW-1:0]            mem_r [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr_r;
    logic [AW-1:0]            rd_ptr_r;
    logic [FW-1:0]            fill_r;
    logic [READY_LATENCY-1:0] rh_r;

    logic          permit_s;
    logic          write_s;
    logic          read_s;
    logic          in_ready_s;
    logic          out_valid_s;
    logic [PW-1:0] in_payload_s;
    logic [PW-1:0] head_s;

    assign permit_s     = rh_r[READY_LATENCY-1];
    assign in_payload_s = {in_data, in_startofpacket, in_endofpacket, in_empty};
    assign head_s       = mem_r[rd_ptr_r];

    // Handshake decode: ready comes only from the registered fill count, and a
    // granted slot consumes the head beat without looking at current out_ready.
    always_comb begin
        in_ready_s  = 1'b0;
        out_valid_s = 1'b0;
        if (reset) begin
            in_ready_s = 1'b0;
        end else begin
            in_ready_s = (fill_r < DEPTH_C);
        end
        if (permit_s && (fill_r != {FW{1'b0}})) begin
            out_valid_s = 1'b1;
        end else begin
            out_valid_s = 1'b0;
        end
    end

    assign write_s = in_valid & in_ready_s;
    assign read_s  = out_valid_s;

    // Ready history: rh_r[k] holds out_ready from k+1 cycles ago.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rh_r <= {READY_LATENCY{1'b0}};
        end else begin
            rh_r[0] <= out_ready;
            for (int k = 1; k < READY_LATENCY; k++) begin
                rh_r[k] <= rh_r[k-1];
            end
        end
    end

    // Storage array: cleared on reset so the head mux never shows X.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {PW{1'b0}};
            end
        end else if (write_s) begin
            mem_r[wr_ptr_r] <= in_payload_s;
        end
    end

    // Read/write pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
        end else begin
            if (write_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (read_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
        end
    end

    // Occupancy counter: +1 on write only, -1 on read only, hold otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_r <= {FW{1'b0}};
        end else begin
            case ({write_s, read_s})
                2'b10:   fill_r <= fill_r + FW'(1);
                2'b01:   fill_r <= fill_r - FW'(1);
                default: fill_r <= fill_r;
            endcase
        end
    end

    assign in_ready          = in_ready_s;
    assign out_valid         = out_valid_s;
    assign out_data          = head_s[PW-1 -: DATA_WIDTH];
    assign out_startofpacket = head_s[EMPTY_WIDTH+1];
    assign out_endofpacket   = head_s[EMPTY_WIDTH];
    assign out_empty         = head_s[EMPTY_WIDTH-1:0];
    assign fill_level        = fill_r;

`ifdef TIMING_ADAPTER_SRC_PKTCHK_EN
    logic pkt_open_r;
    logic pkt_error_r;
    logic frame_err_s;
    logic pkt_open_nxt_s;

    // Framing check on each accepted beat; tracks whether a packet is open.
    always_comb begin
        frame_err_s    = 1'b0;
        pkt_open_nxt_s = pkt_open_r;
        if (write_s) begin
            frame_err_s = (in_startofpacket && pkt_open_r) ||
                          (!in_startofpacket && !pkt_open_r) ||
                          ((in_empty != {EMPTY_WIDTH{1'b0}}) && !in_endofpacket);
            if (in_startofpacket) begin
                pkt_open_nxt_s = !in_endofpacket;
            end else if (in_endofpacket) begin
                pkt_open_nxt_s = 1'b0;
            end else begin
                pkt_open_nxt_s = pkt_open_r;
            end
        end else begin
            frame_err_s    = 1'b0;
            pkt_open_nxt_s = pkt_open_r;
        end
    end

    // Packet-open state and sticky error flag; only reset clears the flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pkt_open_r  <= 1'b0;
            pkt_error_r <= 1'b0;
        end else begin
            pkt_open_r  <= pkt_open_nxt_s;
            pkt_error_r <= pkt_error_r | frame_err_s;
        end
    end

    assign pkt_error = pkt_error_r;
`endif

endmodule

// File: tb/tb_timing_adapter_src_rl.sv
// Directed bench for timing_adapter_src_rl (RL=2, depth 4). Inputs change 1
// time unit after the rising edge; outputs are sampled on the falling edge.
module tb_timing_adapter_src_rl;

    logic        clk;
    logic        reset;
    logic        in_ready;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_startofpacket;
    logic        in_endofpacket;
    logic [1:0]  in_empty;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_startofpacket;
    logic        out_endofpacket;
    logic [1:0]  out_empty;
    logic [2:0]  fill_level;
`ifdef TIMING_ADAPTER_SRC_PKTCHK_EN
    logic        pkt_error;
`endif

    int errors = 0;
    int checks = 0;

    timing_adapter_src_rl #(
        .DATA_WIDTH(32), .EMPTY_WIDTH(2), .READY_LATENCY(2), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset),
        .in_ready(in_ready), .in_valid(in_valid), .in_data(in_data),
        .in_startofpacket(in_startofpacket), .in_endofpacket(in_endofpacket),
        .in_empty(in_empty),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket),
        .out_empty(out_empty),
`ifdef TIMING_ADAPTER_SRC_PKTCHK_EN
        .pkt_error(pkt_error),
`endif
        .fill_level(fill_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_before;
        logic        iv;
        logic [31:0] d;
        logic        sop;
        logic        eop;
        logic [1:0]  emp;
        logic        ordy;
        logic        e_ir;
        logic        e_ov;
        logic [31:0] e_d;
        logic        e_sop;
        logic        e_eop;
        logic [1:0]  e_emp;
        logic [2:0]  e_fill;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic rb, input logic iv, input logic [31:0] d,
                                input logic sop, input logic eop, input logic [1:0] emp,
                                input logic ordy, input logic e_ir, input logic e_ov,
                                input logic [31:0] e_d, input logic e_sop, input logic e_eop,
                                input logic [1:0] e_emp, input logic [2:0] e_fill);
        vec_t v;
        v.rst_before = rb; v.iv = iv; v.d = d; v.sop = sop; v.eop = eop; v.emp = emp;
        v.ordy = ordy; v.e_ir = e_ir; v.e_ov = e_ov; v.e_d = e_d; v.e_sop = e_sop;
        v.e_eop = e_eop; v.e_emp = e_emp; v.e_fill = e_fill;
        vq.push_back(v);
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic step(input logic iv, input logic [31:0] d, input logic sop,
                        input logic eop, input logic [1:0] emp, input logic ordy);
        @(posedge clk);
        #1;
        in_valid = iv; in_data = d; in_startofpacket = sop;
        in_endofpacket = eop; in_empty = emp; out_ready = ordy;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1; in_valid = 1'b0; in_data = 32'd0; in_startofpacket = 1'b0;
        in_endofpacket = 1'b0; in_empty = 2'd0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
        in_startofpacket = 1'b1; in_endofpacket = 1'b0; in_empty = 2'd0; out_ready = 1'b1;

        // Reset held 3 cycles with in_valid high.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_in_ready", c, {31'd0, in_ready}, 32'd0);
            chk("rst_out_valid", c, {31'd0, out_valid}, 32'd0);
            chk("rst_fill", c, {29'd0, fill_level}, 32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 0, {31'd0, in_ready}, 32'd1);

        // Streaming: out_ready held 1, beats 0..7, empty=2.
        add(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 3'd0);
        add(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 3'd0);
        add(1'b0, 1'b1, 32'd0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 3'd0);
        for (int k = 1; k <= 7; k++) begin
            add(1'b0, 1'b1, 32'(k), 1'b0, (k == 7), 2'd2, 1'b1, 1'b1, 1'b1,
                32'(k - 1), (k == 1), 1'b0, 2'd2, 3'd1);
        end
        add(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 32'd7, 1'b0, 1'b1, 2'd2, 3'd1);
        add(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 3'd0);

        // Full FIFO then release: 5 beats offered, 4 accepted while out_ready=0.
        for (int k = 0; k < 4; k++) begin
            add((k == 0), 1'b1, 32'h40 + 32'(k), (k == 0), 1'b0, 2'd0, 1'b0,
                1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 3'(k));
        end
        add(1'b0, 1'b1, 32'h44, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 3'd4);
        add(1'b0, 1'b1, 32'h44, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 3'd4);
        add(1'b0, 1'b1, 32'h44, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 3'd4);
        add(1'b0, 1'b1, 32'h44, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 2'd0, 3'd4);
        add(1'b0, 1'b1, 32'h44, 1'b0, 1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 32'h41, 1'b0, 1'b0, 2'd0, 3'd3);
        add(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 32'h42, 1'b0, 1'b0, 2'd0, 3'd3);
        add(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 32'h43, 1'b0, 1'b0, 2'd0, 3'd2);
        add(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 32'h44, 1'b0, 1'b1, 2'd0, 3'd1);
        add(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 3'd0);

        // Empty FIFO with granted slots: no output, no underflow.
        for (int k = 0; k < 4; k++) begin
            add(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 3'd0);
        end

        for (int i = 0; i < vq.size(); i++) begin
            if (vq[i].rst_before) do_reset();
            step(vq[i].iv, vq[i].d, vq[i].sop, vq[i].eop, vq[i].emp, vq[i].ordy);
            chk("vec_in_ready", i, {31'd0, in_ready}, {31'd0, vq[i].e_ir});
            chk("vec_out_valid", i, {31'd0, out_valid}, {31'd0, vq[i].e_ov});
            chk("vec_fill", i, {29'd0, fill_level}, {29'd0, vq[i].e_fill});
            if (vq[i].e_ov) begin
                chk("vec_data", i, out_data, vq[i].e_d);
                chk("vec_sop", i, {31'd0, out_startofpacket}, {31'd0, vq[i].e_sop});
                chk("vec_eop", i, {31'd0, out_endofpacket}, {31'd0, vq[i].e_eop});
                chk("vec_empty", i, {30'd0, out_empty}, {30'd0, vq[i].e_emp});
            end
        end

        // Single out_ready pulse with 3 beats held: exactly one beat, 2 cycles later.
        do_reset();
        for (int k = 0; k < 3; k++) step(1'b1, 32'h10 + 32'(k), (k == 0), 1'b0, 2'd0, 1'b0);
        for (int k = 0; k < 6; k++) step(1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 1'b0);
        chk("pulse_pre_fill", 0, {29'd0, fill_level}, 32'd3);
        step(1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 1'b1);
        chk("pulse_ov_p0", 0, {31'd0, out_valid}, 32'd0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 1'b0);
        chk("pulse_ov_p1", 0, {31'd0, out_valid}, 32'd0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 1'b0);
        chk("pulse_ov_p2", 0, {31'd0, out_valid}, 32'd1);
        chk("pulse_data_p2", 0, out_data, 32'h10);
        chk("pulse_fill_p2", 0, {29'd0, fill_level}, 32'd3);
        step(1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 1'b0);
        chk("pulse_ov_p3", 0, {31'd0, out_valid}, 32'd0);
        chk("pulse_fill_p3", 0, {29'd0, fill_level}, 32'd2);
        step(1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 1'b1);
        chk("pulse_ov_p4", 0, {31'd0, out_valid}, 32'd0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 1'b1);

        // Reset with beats held and slot granted: contents dropped immediately.
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", 0, {31'd0, out_valid}, 32'd0);
        chk("midrst_fill", 0, {29'd0, fill_level}, 32'd0);
        chk("midrst_in_ready", 0, {31'd0, in_ready}, 32'd0);
        do_reset();

        // Two SOP beats back to back, then drain.
        step(1'b1, 32'h60, 1'b1, 1'b0, 2'd0, 1'b0);
        chk("frm_fill0", 0, {29'd0, fill_level}, 32'd0);
        step(1'b1, 32'h61, 1'b1, 1'b0, 2'd0, 1'b0);
`ifdef TIMING_ADAPTER_SRC_PKTCHK_EN
        chk("pkt_error_after_first", 0, {31'd0, pkt_error}, 32'd0);
`endif
        step(1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 1'b1);
`ifdef TIMING_ADAPTER_SRC_PKTCHK_EN
        chk("pkt_error_set", 0, {31'd0, pkt_error}, 32'd1);
`endif
        chk("frm_fill2", 0, {29'd0, fill_level}, 32'd2);
        step(1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 1'b1);
        chk("frm_ov_wait", 0, {31'd0, out_valid}, 32'd0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 1'b1);
        chk("frm_ov_a", 0, {31'd0, out_valid}, 32'd1);
        chk("frm_data_a", 0, out_data, 32'h60);
        chk("frm_sop_a", 0, {31'd0, out_startofpacket}, 32'd1);
        step(1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 1'b1);
        chk("frm_ov_b", 0, {31'd0, out_valid}, 32'd1);
        chk("frm_data_b", 0, out_data, 32'h61);
        chk("frm_sop_b", 0, {31'd0, out_startofpacket}, 32'd1);
        chk("frm_eop_b", 0, {31'd0, out_endofpacket}, 32'd0);
        step(1'b0, 32'd0, 1'b0, 1'b0, 2'd0, 1'b0);
        chk("frm_ov_end", 0, {31'd0, out_valid}, 32'd0);
        chk("frm_fill_end", 0, {29'd0, fill_level}, 32'd0);
`ifdef TIMING_ADAPTER_SRC_PKTCHK_EN
        chk("pkt_error_sticky", 0, {31'd0, pkt_error}, 32'd1);
        do_reset();
        @(negedge clk);
        chk("pkt_error_cleared", 0, {31'd0, pkt_error}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
